signed_multiply_accumulate: RTL
===============================

// Module: signed_multiply_accumulate
// PURPOSE
//  Sequential signed shift-and-add multiplier with accumulate: P = A*B + C.
//  Inverse of the signed long divider. Reconstructs N = Q*D + R from a divider
//  result for self-check, and serves as a general multi-cycle multiplier.
//  Uses a VALID-in / READY-out handshake. One partial product per clock.
// PARAMETERS
//  W  32  operand width (A, B, C), two's complement; P is 2*W bits
// PORTS
//  clk     in   1    single clock; all state updates on posedge clk
//  reset   in   1    synchronous, active-high; priority over all other inputs
//  VALID   in   1    start request; sampled only in IDLE
//  A       in   W    signed multiplicand (e.g. quotient Q)
//  B       in   W    signed multiplier (e.g. divisor D)
//  C       in   W    signed addend (e.g. remainder R), sign-extended to 2W
//  READY   out  1    one-cycle pulse: P/OVF hold the new result
//  BUSY    out  1    high whenever state != IDLE
//  P       out  2W   signed result A*B+C; holds until next result or reset
//  OVF     out  1    P not representable in W-bit signed; valid with P
// BEHAVIOUR
//  Reset values: READY=0, BUSY=0, P=0, OVF=0, state=IDLE, counter=0.
//  States: IDLE -> RUN -> FIX -> DONE -> IDLE.
//   IDLE: when VALID=1 at an edge, latch |A|, |B| as W-bit unsigned magnitudes.
//         Latch sign = A[W-1]^B[W-1], latch C. Clear accumulator. cnt=0 -> RUN.
//   RUN: each edge, if mag_B[0] then acc += mag_A (2W wide). Then shift
//        mag_A left 1, mag_B right 1, and cnt++. Leave after the edge with
//        cnt==W-1 (exactly W edges in RUN) -> FIX.
//   FIX: P <= (sign ? -acc : acc) + sext(C). OVF <= (P[2W-1:W-1] not all
//        equal). READY <= 1. -> DONE.
//   DONE: READY <= 0 at next edge. -> IDLE.
//  Latency: VALID accepted at edge t. P/OVF/READY update at edge t+W+1.
//   READY is high for exactly the cycle between edges t+W+1 and t+W+2.
//   Earliest next accept is edge t+W+3, so the issue interval is W+3 clocks.
//  Operands are captured at acceptance; A/B/C changes during RUN/FIX/DONE are
//   ignored. VALID outside IDLE is ignored, never queued.
//  Width rules: magnitude of -2^(W-1) is 2^(W-1) and fits W-bit unsigned.
//   |A*B| <= 2^(2W-2) and |C| <= 2^(W-1), so the 2W-bit P never wraps.
//  Zero operands take the full W+1 cycles (no early termination); P = sext(C).
//  Reset mid-operation (any state): abandon the op. Next edge gives IDLE,
//   BUSY=0, READY=0 (no pulse), P=0, OVF=0.
//  Reset and VALID high together: reset wins, nothing accepted.
//  VALID held high continuously: a new op is accepted at every IDLE edge.
// TESTING
//  1 reset; VALID 1 cycle, A=7, B=-3, C=2 -> READY after W+1 edges (33),
//    P=-19 (0xFFFF_FFFF_FFFF_FFED), OVF=0, BUSY low 1 cycle after READY drops.
//  2 A=0x8000_0000, B=0x8000_0000, C=0 -> P=0x4000_0000_0000_0000, OVF=1.
//    Also A=0x8000_0000, B=1, C=-1 -> P=0xFFFF_FFFF_7FFF_FFFF, OVF=1.
//  3 Divider round-trip: A=-33, B=3, C=-1 -> P=-100, OVF=0.
//    A=0, B=12345, C=-5 -> P=0xFFFF_FFFF_FFFF_FFFB.
//  4 VALID held high: A=3, B=4, C=0, then A=100 during RUN -> first P=12.
//    Second accept lands exactly W+3 edges after the first (P=400).
//  5 Assert reset for 1 cycle at RUN cnt=10 -> no READY pulse, P=0, BUSY=0.
//    Then A=5, B=5, C=5 -> P=30.
//  6 Random signed A/B/C (>=1000 ops, incl. +/-2^(W-1), 0, -1) vs model A*B+C.
//    Check P, OVF, and that READY is exactly 1 cycle wide.

Source files
------------

// File: rtl/signed_multiply_accumulate.sv
// Sequential signed shift-and-add multiply-accumulate: P = A*B + C.
// Magnitudes are multiplied unsigned, one partial product per clock, then the
// sign is reapplied and the sign-extended addend is added in a single FIX cycle.
module signed_multiply_accumulate #(
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             VALID,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [W-1:0]     C,
    output logic             READY,
    output logic             BUSY,
    output logic [2*W-1:0]   P,
    output logic             OVF
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] mag_a_q, mag_a_d;
    logic [W-1:0]  mag_b_q, mag_b_d;
    logic          sign_q, sign_d;
    logic [W-1:0]  c_q, c_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] p_q, p_d;
    logic          ovf_q, ovf_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    // Two's-complement magnitudes; |-2^(W-1)| = 2^(W-1) still fits W-bit unsigned
    logic [W-1:0]  mag_a_in_c, mag_b_in_c;
    logic [PW-1:0] signed_acc_c;

    always_comb begin
        mag_a_in_c = A[W-1] ? (~A + W'(1)) : A;
        mag_b_in_c = B[W-1] ? (~B + W'(1)) : B;
    end

    // Next-state and datapath: operand capture, shift-add, sign fix, result hold
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mag_a_d      = mag_a_q;
        mag_b_d      = mag_b_q;
        sign_d       = sign_q;
        c_d          = c_q;
        acc_d        = acc_q;
        p_d          = p_q;
        ovf_d        = ovf_q;
        ready_d      = 1'b0;
        signed_acc_c = sign_q ? (~acc_q + PW'(1)) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (VALID) begin
                    mag_a_d = {W'(0), mag_a_in_c};
                    mag_b_d = mag_b_in_c;
                    sign_d  = A[W-1] ^ B[W-1];
                    c_d     = C;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (mag_b_q[0]) begin
                    acc_d = acc_q + mag_a_q;
                end
                mag_a_d = mag_a_q << 1;
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                p_d     = signed_acc_c + {{W{c_q[W-1]}}, c_q};
                ovf_d   = !((&p_d[PW-1:W-1]) || !(|p_d[PW-1:W-1]));
                ready_d = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            sign_q  <= 1'b0;
            c_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            sign_q  <= sign_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign P     = p_q;
    assign OVF   = ovf_q;
    assign READY = ready_q;
    assign BUSY  = busy_q;

endmodule
